// File: rtl/operand_loader_8_bits.sv
// Byte-serial operand loader: accepts A then B over a valid/ready bus and presents the pair.
// Optional WAIT_B abort timer is built when OPERAND_LOADER_TIMEOUT_EN is defined.
module operand_loader_8_bits #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       pair_count,
    output logic             timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitB   = 2'd1,
        StPresent = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       pair_count_q, pair_count_d;

`ifdef OPERAND_LOADER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        pair_count_d = pair_count_q;
`ifdef OPERAND_LOADER_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = data_in;
                    state_d = StWaitB;
`ifdef OPERAND_LOADER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StWaitB: begin
                if (in_valid) begin
                    b_d     = data_in;
                    state_d = StPresent;
                end
`ifdef OPERAND_LOADER_TIMEOUT_EN
                // An arriving B on the expiry edge takes priority over the abort.
                else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StPresent: begin
                if (out_ready) begin
                    state_d      = StIdle;
                    pair_count_d = pair_count_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pair_count_q <= pair_count_d;
        end
    end

`ifdef OPERAND_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ready   = (state_q != StPresent);
    assign out_valid  = (state_q == StPresent);
    assign A          = a_q;
    assign B          = b_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_operand_loader_8_bits.sv
// Self-checking bench for operand_loader_8_bits: transaction-level model checked every cycle
// plus directed literal expectations.
module tb_operand_loader_8_bits;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dut_a;
    logic [7:0] dut_b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] pair_count;
    logic       timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    operand_loader_8_bits #(
        .WIDTH          (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (dut_a),
        .B           (dut_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pair_count  (pair_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction model: a pair is "pending" once two bytes have been taken and until consumed.
    logic [7:0] m_a, m_b, m_count;
    bit         m_have_a, m_pending, m_err, m_live;
    int         m_idle;

    initial begin
        m_live = 0;
        m_a = 0; m_b = 0; m_count = 0;
        m_have_a = 0; m_pending = 0; m_err = 0; m_idle = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_a = 8'h00; m_b = 8'h00; m_count = 8'h00;
            m_have_a = 0; m_pending = 0; m_err = 0; m_idle = 0;
            m_live = 1;
        end else begin
            m_err = 0;
            if (m_pending) begin
                if (out_ready) begin
                    m_pending = 0;
                    m_count   = m_count + 8'd1;
                end
            end else if (in_valid) begin
                if (!m_have_a) begin
                    m_a = data_in; m_have_a = 1; m_idle = 0;
                end else begin
                    m_b = data_in; m_have_a = 0; m_pending = 1;
                end
            end else if (m_have_a) begin
`ifdef OPERAND_LOADER_TIMEOUT_EN
                m_idle++;
                if (m_idle == int'(TO)) begin
                    m_have_a = 0;
                    m_err    = 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",    in_ready,    !m_pending);
            chk("out_valid",   out_valid,   m_pending);
            chk("A",           dut_a,       m_a);
            chk("B",           dut_b,       m_b);
            chk("pair_count",  pair_count,  m_count);
            chk("timeout_err", timeout_err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        data_in  = b;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (n == 20) chk("send_byte_ready_bound", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        data_in  = 8'hEE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_A", dut_a, 8'h00);
        chk("rst_B", dut_b, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_pair_count", pair_count, 8'd0);

        // Back-to-back pair, consumer always ready
        out_ready = 1'b1;
        send_byte(8'hFF);
        send_byte(8'h00);
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_A", dut_a, 8'hFF);
        chk("t2_B", dut_b, 8'h00);
        chk("t2_and", dut_a & dut_b, 8'h00);
        cyc();
        chk("t2_out_valid_drop", out_valid, 1'b0);
        chk("t2_pair_count", pair_count, 8'd1);

        // Back-pressure, with an attempted overlapping byte
        out_ready = 1'b0;
        send_byte(8'hFF);
        send_byte(8'hA9);
        in_valid = 1'b1;
        data_in  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", out_valid, 1'b1);
            chk("t3_hold_ready", in_ready, 1'b0);
            chk("t3_hold_A", dut_a, 8'hFF);
            chk("t3_hold_B", dut_b, 8'hA9);
            cyc();
        end
        out_ready = 1'b1;
        chk("t3_and", dut_a & dut_b, 8'hA9);
        cyc();
        in_valid = 1'b0;
        chk("t3_out_valid_drop", out_valid, 1'b0);
        chk("t3_pair_count", pair_count, 8'd2);
        chk("t3_A_kept", dut_a, 8'hFF);

        // Gapped valid: only the valid bytes are taken
        in_valid = 1'b1; data_in = 8'hFF; cyc();
        in_valid = 1'b0; data_in = 8'h11; cyc();
        in_valid = 1'b0; data_in = 8'h22; cyc();
        in_valid = 1'b1; data_in = 8'hFF; cyc();
        in_valid = 1'b0;
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_and", dut_a & dut_b, 8'hFF);
        cyc();
        chk("t4_pair_count", pair_count, 8'd3);

        // Reset while waiting for B discards the partial pair
        out_ready = 1'b0;
        send_byte(8'h3C);
        chk("t5_A_loaded", dut_a, 8'h3C);
        do_reset();
        chk("t5_rst_A", dut_a, 8'h00);
        chk("t5_rst_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send_byte(8'h0F);
        send_byte(8'hF0);
        chk("t5_A", dut_a, 8'h0F);
        chk("t5_B", dut_b, 8'hF0);
        chk("t5_and", dut_a & dut_b, 8'h00);
        cyc();
        chk("t5_pair_count", pair_count, 8'd1);

        out_ready = 1'b0;
`ifdef OPERAND_LOADER_TIMEOUT_EN
        // Abort after TO idle edges in WAIT_B
        send_byte(8'h3C);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_no_err_early", timeout_err, 1'b0);
        end
        cyc();
        chk("t6_err_pulse", timeout_err, 1'b1);
        chk("t6_idle_ready", in_ready, 1'b1);
        chk("t6_A_retained", dut_a, 8'h3C);
        cyc();
        chk("t6_err_cleared", timeout_err, 1'b0);
        chk("t6_no_present", out_valid, 1'b0);
        // B arriving on the expiry edge wins
        send_byte(8'h3C);
        for (int i = 0; i < 3; i++) cyc();
        send_byte(8'h5A);
        chk("t6_race_no_err", timeout_err, 1'b0);
        chk("t6_race_valid", out_valid, 1'b1);
        chk("t6_race_B", dut_b, 8'h5A);
`else
        // Without the timer WAIT_B waits indefinitely
        send_byte(8'h3C);
        for (int i = 0; i < 20; i++) cyc();
        chk("t6_still_wait", in_ready, 1'b1);
        chk("t6_err_tied", timeout_err, 1'b0);
        send_byte(8'h5A);
        chk("t6_late_valid", out_valid, 1'b1);
        chk("t6_late_and", dut_a & dut_b, 8'h18);
`endif
        out_ready = 1'b1;
        cyc();

        // Counter wrap after 256 pairs
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            send_byte(8'($urandom_range(0, 255)));
            cyc();
            if (i == 254) chk("t7_count_255", pair_count, 8'd255);
        end
        chk("t7_count_wrap", pair_count, 8'd0);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
